// File: rtl/shared_queue_ctrl.sv
// shared_queue_ctrl: enqueue/dequeue front end for a shared-memory linked-list allocator.
// Enqueues write payloads into a data RAM at the allocator's free slot and strobe ll_push.
// A dequeue arbiter pops one non-empty list into a one-entry registered output.
// Optional feature: define SHARED_QUEUE_RR_EN for round-robin arbitration; otherwise the
// lowest-index non-empty list always wins.
module shared_queue_ctrl #(
    parameter int unsigned NUM_ELEMS  = 4,
    parameter int unsigned NUM_LISTS  = 2,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PTR_WIDTH  = $clog2(NUM_ELEMS),
    parameter int unsigned SEL_WIDTH  = $clog2(NUM_LISTS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enq_valid,
    input  logic [SEL_WIDTH-1:0]  enq_qid,
    input  logic [DATA_WIDTH-1:0] enq_data,
    output logic                  enq_ready,
    output logic                  deq_valid,
    output logic [SEL_WIDTH-1:0]  deq_qid,
    output logic [DATA_WIDTH-1:0] deq_data,
    input  logic                  deq_ready,
    output logic                  ll_push,
    output logic                  ll_pop,
    output logic [SEL_WIDTH-1:0]  ll_push_sel,
    output logic [SEL_WIDTH-1:0]  ll_pop_sel,
    input  logic                  ll_full,
    input  logic [NUM_LISTS-1:0]  ll_empty,
    input  logic [PTR_WIDTH-1:0]  ll_free_ptr,
    input  logic [PTR_WIDTH-1:0]  ll_popped_head
);

    logic [DATA_WIDTH-1:0] mem_q [NUM_ELEMS];

    logic                  deq_valid_q;
    logic [SEL_WIDTH-1:0]  deq_qid_q;
    logic [DATA_WIDTH-1:0] deq_data_q;

    logic                  slot_open;
    logic [NUM_LISTS-1:0]  eligible;
    logic                  any_eligible;
    logic [SEL_WIDTH-1:0]  grant;
    logic [SEL_WIDTH-1:0]  scan_idx;
    logic                  found;

    // No same-cycle reuse of a freed slot: readiness depends only on the registered full flag.
    assign enq_ready    = !ll_full;
    assign ll_push      = enq_valid && enq_ready && !rst;
    assign ll_push_sel  = enq_qid;

    // Empty flags are registered in the allocator, so same-cycle pushes are never eligible.
    assign eligible     = ~ll_empty;
    assign any_eligible = |eligible;
    assign slot_open    = !deq_valid_q || deq_ready;

    assign ll_pop       = slot_open && any_eligible && !rst;
    assign ll_pop_sel   = grant;

    assign deq_valid    = deq_valid_q;
    assign deq_qid      = deq_qid_q;
    assign deq_data     = deq_data_q;

`ifdef SHARED_QUEUE_RR_EN
    logic [SEL_WIDTH-1:0] rr_ptr_q;
    logic [SEL_WIDTH-1:0] rr_ptr_d;

    // Round-robin grant: first eligible list at or after the priority pointer.
    always_comb begin
        grant    = '0;
        found    = 1'b0;
        scan_idx = '0;
        for (int k = 0; k < NUM_LISTS; k++) begin
            scan_idx = SEL_WIDTH'((int'(rr_ptr_q) + k) % NUM_LISTS);
            if (!found && eligible[scan_idx]) begin
                grant = scan_idx;
                found = 1'b1;
            end
        end
        rr_ptr_d = SEL_WIDTH'((int'(grant) + 1) % NUM_LISTS);
    end

    // Priority pointer moves past the granted list only when a pop actually happens.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
        end else if (ll_pop) begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`else
    // Fixed priority grant: lowest-index eligible list.
    always_comb begin
        grant    = '0;
        found    = 1'b0;
        scan_idx = '0;
        for (int k = 0; k < NUM_LISTS; k++) begin
            scan_idx = SEL_WIDTH'(k);
            if (!found && eligible[scan_idx]) begin
                grant = scan_idx;
                found = 1'b1;
            end
        end
    end
`endif

    // Data RAM write at the allocator's free slot; no reset, every live slot is written on push.
    always_ff @(posedge clk) begin
        if (ll_push) begin
            mem_q[ll_free_ptr] <= enq_data;
        end
    end

    // Output register: load the popped head when the slot is open, clear when nothing to pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            deq_valid_q <= 1'b0;
            deq_qid_q   <= '0;
            deq_data_q  <= '0;
        end else if (slot_open) begin
            deq_valid_q <= any_eligible;
            if (any_eligible) begin
                deq_qid_q  <= grant;
                deq_data_q <= mem_q[ll_popped_head];
            end
        end
    end

endmodule

// File: tb/tb_shared_queue_ctrl.sv
// Testbench for shared_queue_ctrl: a behavioural linked-list allocator drives the allocator
// inputs, and a per-queue payload model predicts every handshake and output value.
module tb_shared_queue_ctrl;

    localparam int unsigned NE = 4;
    localparam int unsigned NL = 2;
    localparam int unsigned DW = 8;
    localparam int unsigned PW = 2;
    localparam int unsigned SW = 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enq_valid = 1'b0;
    logic [SW-1:0] enq_qid = '0;
    logic [DW-1:0] enq_data = '0;
    logic          enq_ready;
    logic          deq_valid;
    logic [SW-1:0] deq_qid;
    logic [DW-1:0] deq_data;
    logic          deq_ready = 1'b0;
    logic          ll_push, ll_pop;
    logic [SW-1:0] ll_push_sel, ll_pop_sel;
    logic          ll_full;
    logic [NL-1:0] ll_empty;
    logic [PW-1:0] ll_free_ptr;
    logic [PW-1:0] ll_popped_head;

    shared_queue_ctrl #(
        .NUM_ELEMS (NE),
        .NUM_LISTS (NL),
        .DATA_WIDTH(DW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enq_valid     (enq_valid),
        .enq_qid       (enq_qid),
        .enq_data      (enq_data),
        .enq_ready     (enq_ready),
        .deq_valid     (deq_valid),
        .deq_qid       (deq_qid),
        .deq_data      (deq_data),
        .deq_ready     (deq_ready),
        .ll_push       (ll_push),
        .ll_pop        (ll_pop),
        .ll_push_sel   (ll_push_sel),
        .ll_pop_sel    (ll_pop_sel),
        .ll_full       (ll_full),
        .ll_empty      (ll_empty),
        .ll_free_ptr   (ll_free_ptr),
        .ll_popped_head(ll_popped_head)
    );

    always #5 clk = ~clk;

    // ---------------- Behavioural allocator: free mask plus per-list pointer FIFOs ----------
    logic [NE-1:0]          free_q, free_d;
    logic [NE-1:0][PW-1:0]  lq_q [NL];
    logic [NE-1:0][PW-1:0]  lq_d [NL];
    int                     cnt_q [NL];
    int                     cnt_d [NL];

    always_comb begin
        ll_full     = (free_q == '0);
        ll_free_ptr = '0;
        for (int e = NE - 1; e >= 0; e--) begin
            if (free_q[e]) ll_free_ptr = PW'(e);
        end
        for (int l = 0; l < NL; l++) ll_empty[l] = (cnt_q[l] == 0);
        ll_popped_head = lq_q[ll_pop_sel][0];
    end

    always_comb begin
        free_d = free_q;
        for (int l = 0; l < NL; l++) begin
            lq_d[l]  = lq_q[l];
            cnt_d[l] = cnt_q[l];
            if (ll_pop && ll_pop_sel == SW'(l)) begin
                for (int e = 0; e < NE - 1; e++) lq_d[l][e] = lq_d[l][e+1];
                cnt_d[l] = cnt_d[l] - 1;
            end
            if (ll_push && ll_push_sel == SW'(l) && cnt_d[l] < NE) begin
                lq_d[l][cnt_d[l]] = ll_free_ptr;
                cnt_d[l] = cnt_d[l] + 1;
            end
        end
        if (ll_push) free_d[ll_free_ptr] = 1'b0;
        if (ll_pop) free_d[ll_popped_head] = 1'b1;
    end

    always @(posedge clk) begin
        if (rst) begin
            free_q <= '1;
            for (int l = 0; l < NL; l++) begin
                lq_q[l]  <= '0;
                cnt_q[l] <= 0;
            end
        end else begin
            free_q <= free_d;
            for (int l = 0; l < NL; l++) begin
                lq_q[l]  <= lq_d[l];
                cnt_q[l] <= cnt_d[l];
            end
        end
    end

    // ---------------- Reference model of the queue front end ----------------
    logic [DW-1:0] refq [NL][$];
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic [SW-1:0] m_qid;
    int            m_p;
    logic [DW-1:0] outlog [$];
    logic [DW-1:0] exp_log [$];

    int checks = 0;
    int passes = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_clear();
        for (int l = 0; l < NL; l++) refq[l].delete();
        m_valid = 1'b0;
        m_data  = '0;
        m_qid   = '0;
        m_p     = 0;
    endtask

    // One clock: drive at the falling edge, check strobes, advance model, check outputs.
    task automatic cycle(input logic ev, input logic [SW-1:0] qid, input logic [DW-1:0] d,
                         input logic dr);
        int            occ;
        int            l;
        logic          fire, open, any;
        logic [SW-1:0] g;
        enq_valid = ev;
        enq_qid   = qid;
        enq_data  = d;
        deq_ready = dr;
        #1;
        occ = 0;
        for (int i = 0; i < NL; i++) occ += refq[i].size();
        fire = ev && (occ < NE);
        open = !m_valid || dr;
        any  = 1'b0;
        g    = '0;
        for (int k = 0; k < NL; k++) begin
`ifdef SHARED_QUEUE_RR_EN
            l = (m_p + k) % NL;
`else
            l = k;
`endif
            if (!any && refq[l].size() > 0) begin
                any = 1'b1;
                g   = SW'(l);
            end
        end
        chk("enq_ready", {31'd0, enq_ready}, {31'd0, occ < NE});
        chk("ll_push", {31'd0, ll_push}, {31'd0, fire});
        if (fire) chk("ll_push_sel", {31'd0, ll_push_sel}, {31'd0, qid});
        chk("ll_pop", {31'd0, ll_pop}, {31'd0, open && any});
        if (open && any) chk("ll_pop_sel", {31'd0, ll_pop_sel}, {31'd0, g});
        if (open) begin
            if (any) begin
                m_data  = refq[g].pop_front();
                m_qid   = g;
                m_valid = 1'b1;
                m_p     = (int'(g) + 1) % NL;
            end else begin
                m_valid = 1'b0;
            end
        end
        if (fire) refq[qid].push_back(d);
        @(posedge clk);
        @(negedge clk);
        chk("deq_valid", {31'd0, deq_valid}, {31'd0, m_valid});
        if (m_valid) begin
            chk("deq_data", {24'd0, deq_data}, {24'd0, m_data});
            chk("deq_qid", {31'd0, deq_qid}, {31'd0, m_qid});
        end
        if (open && any) outlog.push_back(deq_data);
    endtask

    // Reset for one cycle with requests active; strobes must stay low throughout.
    task automatic do_reset();
        rst       = 1'b1;
        enq_valid = 1'b1;
        deq_ready = 1'b1;
        #1;
        chk("rst_push", {31'd0, ll_push}, 32'd0);
        chk("rst_pop", {31'd0, ll_pop}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst       = 1'b0;
        enq_valid = 1'b0;
        deq_ready = 1'b0;
        #1;
        chk("rst_deq_valid", {31'd0, deq_valid}, 32'd0);
        chk("rst_deq_data", {24'd0, deq_data}, 32'd0);
        chk("rst_deq_qid", {31'd0, deq_qid}, 32'd0);
        chk("rst_enq_ready", {31'd0, enq_ready}, 32'd1);
        model_clear();
        outlog.delete();
        @(negedge clk);
    endtask

    task automatic chk_log(input string tag);
        chk({tag, "_len"}, outlog.size(), exp_log.size());
        for (int i = 0; i < exp_log.size(); i++) begin
            if (i < outlog.size()) chk(tag, {24'd0, outlog[i]}, {24'd0, exp_log[i]});
        end
    endtask

    initial begin
        model_clear();
        do_reset();

        // Single enqueue, two-cycle latency to the output.
        cycle(1'b1, 1'b0, 8'hA1, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 8'h00, 1'b1);
        exp_log = '{8'hA1};
        chk_log("single");

        // Fill to full on q1 with the consumer stalled, then the full boundary.
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, DW'(8'h10 + i), 1'b0);
        cycle(1'b1, 1'b1, 8'hEE, 1'b1);  // full: refused even though a pop fires
        cycle(1'b1, 1'b1, 8'h77, 1'b1);  // capacity back one cycle later
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 8'h00, 1'b1);
        exp_log = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h77};
        chk_log("full");

        // Two queues with two entries each: arbitration order.
        do_reset();
        cycle(1'b1, 1'b0, 8'h01, 1'b0);
        cycle(1'b1, 1'b1, 8'h81, 1'b0);
        cycle(1'b1, 1'b0, 8'h02, 1'b0);
        cycle(1'b1, 1'b1, 8'h82, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 8'h00, 1'b1);
`ifdef SHARED_QUEUE_RR_EN
        exp_log = '{8'h01, 8'h81, 8'h02, 8'h82};
`else
        exp_log = '{8'h01, 8'h02, 8'h81, 8'h82};
`endif
        chk_log("arb");

        // Enqueue into a one-element list in the same cycle it is popped.
        do_reset();
        cycle(1'b1, 1'b0, 8'h33, 1'b0);
        cycle(1'b1, 1'b0, 8'h55, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 8'h00, 1'b1);
        exp_log = '{8'h33, 8'h55};
        chk_log("same_cycle");

        // Held output for three cycles, then reset with three entries queued.
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1'b1, SW'(i % 2), DW'(8'hC0 + i), 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 8'h00, 1'b0);
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 8'h00, 1'b1);
        chk("no_stale", outlog.size(), 32'd0);

        // Randomized traffic against the model, then drain.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 9) < 6), SW'($urandom_range(0, NL - 1)),
                  DW'($urandom), ($urandom_range(0, 1) == 1));
        end
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 8'h00, 1'b1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
